cbuf_frame_reader: RTL and testbench



---
 rtl/cbuf_frame_reader.sv | 184 ++++++++++++++++++
 tb/tb_cbuf_frame_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cbuf_frame_reader.sv
// Read-side sequencer for the circular capture buffer: sweeps relative addresses oldest-first
// and streams samples on ready/valid. Define CBUF_READER_DECIM_EN to step addresses by DECIM.
module cbuf_frame_reader #(
    parameter int BUFFER_LEN = 800,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 12,
    parameter int RAM_LAT    = 2
`ifdef CBUF_READER_DECIM_EN
    ,
    parameter int DECIM      = 2
`endif
) (
    input  logic              r_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] relative_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

`ifdef CBUF_READER_DECIM_EN
    localparam int STEP = DECIM;
`else
    localparam int STEP = 1;
`endif
    localparam int DEPTH = RAM_LAT + 2;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_C   = (ADDR_W + 1)'(BUFFER_LEN);
    localparam logic [ADDR_W:0] STEP_C  = (ADDR_W + 1)'(STEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [RAM_LAT-1:0]  pipe_v_q, pipe_v_d;
    logic [RAM_LAT-1:0]  pipe_l_q, pipe_l_d;
    logic [DATA_W:0]     mem_q [DEPTH];
    logic [DATA_W:0]     mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    occ_q, occ_d;
    logic                done_q, done_d;

    logic [CNT_W-1:0]    infl_cnt;
    logic [CNT_W:0]      credit_sum;
    logic [ADDR_W:0]     addr_next_wide;
    logic                is_last_addr;
    logic                issue;
    logic                push;
    logic                pop;
    logic [DATA_W:0]     head;

    // Handshake: a beat transfers on any posedge where out_valid && out_ready; while out_valid
    // is high and out_ready low, the head entry (out_data, out_last) is not changed.
    assign head          = mem_q[rd_ptr_q];
    assign out_valid     = (occ_q != '0);
    assign out_data      = head[DATA_W-1:0];
    assign out_last      = out_valid & head[DATA_W];
    assign relative_addr = addr_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign dbg_state     = state_q;

    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < RAM_LAT; i++) begin
            infl_cnt = infl_cnt + CNT_W'(pipe_v_q[i]);
        end
        credit_sum     = {1'b0, occ_q} + {1'b0, infl_cnt};
        addr_next_wide = {1'b0, addr_q} + STEP_C;
        is_last_addr   = (addr_next_wide >= LEN_C);
        // Reads in flight are counted against FIFO space so the FIFO can never overflow.
        issue          = (state_q == S_RUN) && (credit_sum < DEPTH_C);
        push           = pipe_v_q[RAM_LAT-1];
        pop            = out_valid && out_ready;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        done_d   = 1'b0;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        pipe_v_d    = '0;
        pipe_l_d    = '0;
        pipe_v_d[0] = issue;
        pipe_l_d[0] = issue && is_last_addr;
        for (int i = 1; i < RAM_LAT; i++) begin
            pipe_v_d[i] = pipe_v_q[i-1];
            pipe_l_d[i] = pipe_l_q[i-1];
        end

        if (push) begin
            mem_d[wr_ptr_q] = {pipe_l_q[RAM_LAT-1], ram_data};
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (is_last_addr) state_d = S_DRAIN;
                    else              addr_d  = addr_next_wide[ADDR_W-1:0];
                end
            end
            S_DRAIN: begin
                if (pop && out_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort discards everything buffered or in flight; the address register just holds.
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            pipe_v_d = '0;
            pipe_l_d = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end
    end

    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            pipe_v_q <= '0;
            pipe_l_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            pipe_v_q <= pipe_v_d;
            pipe_l_q <= pipe_l_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            done_q   <= done_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_cbuf_frame_reader.sv
// Directed bench for cbuf_frame_reader: RAM modelled as relative_addr delayed two cycles,
// expected beats held in a queue of {last, data}.
module tb_cbuf_frame_reader;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 12;
  localparam int W      = DATA_W + 1;
`ifdef CBUF_READER_DECIM_EN
  localparam int STEP_EXP = 2;
`else
  localparam int STEP_EXP = 1;
`endif
  localparam int N_EXP = (800 + STEP_EXP - 1) / STEP_EXP;

  logic              r_clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] relative_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  logic [ADDR_W-1:0] ram_d1, ram_d2;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  cbuf_frame_reader dut (
    .r_clk(r_clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .relative_addr(relative_addr),
    .ram_data(ram_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .done(done),
    .dbg_state(dbg_state)
  );

  // clock / RAM model
  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  always @(posedge r_clk) begin
    ram_d1 <= relative_addr;
    ram_d2 <= ram_d1;
  end
  assign ram_data = {2'b00, ram_d2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_exp();
    logic [W-1:0] v;
    exp_q.delete();
    for (int i = 0; i < N_EXP; i++) begin
      v[DATA_W-1:0] = DATA_W'(i * STEP_EXP);
      v[DATA_W]     = (i == N_EXP - 1);
      exp_q.push_back(v);
    end
  endtask

  task automatic start_pulse(input bit with_abort);
    start = 1'b1;
    abort = with_abort;
    @(negedge r_clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_busy", busy, 1);
    check("start_addr", relative_addr, 0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for first 20 cycles
  task automatic run_frame(input int mode, input int abort_beat, input int restart_cyc,
                           output int busy_cycles);
    int beats, first_cyc, last_cyc;
    bit finished, done_pending, abort_pending, hold;
    logic [W-1:0] held, e;
    beats = 0; first_cyc = -1; last_cyc = -1;
    finished = 0; done_pending = 0; abort_pending = 0; hold = 0;
    held = '0; busy_cycles = 0;
    for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
      start = 1'b0;
      abort = 1'b0;
      if (busy) busy_cycles++;
      if (done_pending) begin
        check("done_pulse", done, 1);
        check("busy_fall", busy, 0);
        finished = 1;
      end else if (abort_pending) begin
        check("abort_valid", out_valid, 0);
        check("abort_done", done, 1);
        check("abort_busy", busy, 0);
        finished = 1;
      end else begin
        check("no_early_done", done, 0);
        if (hold) begin
          check("hold_valid", out_valid, 1);
          check("hold_beat", {out_last, out_data}, held);
        end
        if (mode == 2 && (cyc == 10 || cyc == 19)) check("stall_addr", relative_addr, 4 * STEP_EXP);
        if (cyc == restart_cyc) start = 1'b1;
        case (mode)
          1:       out_ready = 1'($urandom_range(0, 1));
          2:       out_ready = (cyc >= 20);
          default: out_ready = 1'b1;
        endcase
        if (out_valid && out_ready) begin
          if (beats == 0) first_cyc = cyc;
          last_cyc = cyc;
          beats++;
          if (exp_q.size() == 0) begin
            check("extra_beat", beats, N_EXP);
          end else begin
            e = exp_q.pop_front();
            check("beat", {out_last, out_data}, e);
          end
          if (out_last) done_pending = 1;
          if (beats == abort_beat) begin
            abort = 1'b1;
            abort_pending = 1;
            exp_q.delete();
          end
        end
        hold = out_valid && !out_ready;
        held = {out_last, out_data};
      end
      if (!finished) @(negedge r_clk);
    end
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    if (!finished) check("frame_timeout", 0, 1);
    if (abort_beat < 0) check("beat_count", beats, N_EXP);
    if (mode == 0 && abort_beat < 0) begin
      check("first_beat_cyc", first_cyc, 3);
      check("last_beat_cyc", last_cyc, 3 + N_EXP - 1);
    end
  endtask

  initial begin
    int bc;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge r_clk);
    check("rst_addr", relative_addr, 0);
    check("rst_data", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge r_clk);

    // full frame, ready held high
    fill_exp();
    start_pulse(0);
    run_frame(0, -1, -1, bc);
    check("busy_cycles", bc, N_EXP + 3);

    // random backpressure
    fill_exp();
    start_pulse(0);
    run_frame(1, -1, -1, bc);

    // stall for 20 cycles after start
    fill_exp();
    start_pulse(0);
    run_frame(2, -1, -1, bc);

    // abort at the 100th beat, then abort in IDLE is ignored, then a clean frame
    fill_exp();
    start_pulse(0);
    run_frame(0, 100, -1, bc);
    abort = 1'b1;
    @(negedge r_clk);
    abort = 1'b0;
    check("idle_abort_done", done, 0);
    check("idle_abort_busy", busy, 0);
    fill_exp();
    start_pulse(0);
    run_frame(0, -1, -1, bc);
    check("busy_after_abort", bc, N_EXP + 3);

    // reset mid-frame
    fill_exp();
    start_pulse(0);
    repeat (50) @(negedge r_clk);
    rst_n = 1'b0;
    @(negedge r_clk);
    rst_n = 1'b1;
    check("midrst_addr", relative_addr, 0);
    check("midrst_data", out_data, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_last", out_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    repeat (3) @(negedge r_clk);

    // start pulse while busy is ignored
    fill_exp();
    start_pulse(0);
    run_frame(0, -1, 300, bc);
    check("busy_restart", bc, N_EXP + 3);

    // start and abort together in IDLE: start wins
    fill_exp();
    start_pulse(1);
    run_frame(0, -1, -1, bc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
